chunked_subtractor: RTL

//  Inverse of the registered wide adder. Recovers operand b from a (W+1)-bit
//  sum and a W-bit operand a, computing diff = minuend - subtrahend.

---
 rtl/chunked_subtractor_pkg.sv | 25 ++
 rtl/chunked_subtractor_sub_chunk.sv | 21 ++
 rtl/chunked_subtractor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/chunked_subtractor_pkg.sv
// Shared types and sizing helpers for the chunked wide subtractor.
// Sizing is derived from W and CHUNK so NCHUNK can never be overridden by hand.
package chunked_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int w, input int chunk);
    return (w + 1 + chunk - 1) / chunk;
  endfunction

  function automatic int calc_padded_width(input int w, input int chunk);
    return calc_nchunk(w, chunk) * chunk;
  endfunction

  function automatic int calc_idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = calc_idx_width(calc_nchunk(149, 32));

endpackage

// File: rtl/chunked_subtractor_sub_chunk.sv
// One CHUNK-bit slice of the subtractor: {bout, r} = a - b - bin.
module sub_chunk #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] r,
  output logic             bout
);

  logic [CHUNK:0] full_s;

  // Widen by one bit so the borrow falls out as the sign bit of the slice
  always_comb begin
    full_s = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    r      = full_s[CHUNK-1:0];
    bout   = full_s[CHUNK];
  end

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle wide subtractor: diff = minuend - subtrahend, one CHUNK slice per clock.
// Optional range flag enabled by defining SUB_RANGE_CHECK_EN.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int W     = 149,
  parameter int CHUNK = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   minuend,
  input  logic [W-1:0] subtrahend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         range_err
);

  localparam int NCHUNK = calc_nchunk(W, CHUNK);
  localparam int PW     = calc_padded_width(W, CHUNK);
  localparam int IW     = calc_idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_t          state_r;
  logic [PW-1:0]   op_a_r;
  logic [PW-1:0]   op_b_r;
  logic [W-1:0]    res_r;
  logic            borrow_r;
  logic [IW-1:0]   idx_r;

  logic [31:0]     base_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK-1:0] r_s;
  logic            bout_s;
  logic [PW-1:0]   res_next_s;
  logic            unused_pad_s;

  // Select the active slice and merge its difference into the result image
  always_comb begin
    base_s     = 32'(idx_r) * 32'(CHUNK);
    a_slice_s  = op_a_r[base_s +: CHUNK];
    b_slice_s  = op_b_r[base_s +: CHUNK];
    res_next_s = PW'(res_r);
    res_next_s[base_s +: CHUNK] = r_s;
  end

  // Bits at and above W never reach diff; the range flag is taken from r_s directly
  assign unused_pad_s = ^res_next_s[PW-1:W];

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_sub_chunk (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .bin  (borrow_r),
    .r    (r_s),
    .bout (bout_s)
  );

`ifdef SUB_RANGE_CHECK_EN
  // Bit W of the result always lands in the final slice
  localparam int WBIT = W - (NCHUNK - 1) * CHUNK;
  logic range_err_r;
`endif

  // Control FSM, operand capture, borrow chain and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      op_a_r   <= {PW{1'b0}};
      op_b_r   <= {PW{1'b0}};
      res_r    <= {W{1'b0}};
      borrow_r <= 1'b0;
      idx_r    <= {IW{1'b0}};
`ifdef SUB_RANGE_CHECK_EN
      range_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r   <= PW'(minuend);
            op_b_r   <= PW'(subtrahend);
            borrow_r <= 1'b0;
            idx_r    <= {IW{1'b0}};
`ifdef SUB_RANGE_CHECK_EN
            range_err_r <= 1'b0;
`endif
            state_r  <= RUN;
          end
        end
        RUN: begin
          res_r    <= res_next_s[W-1:0];
          borrow_r <= bout_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= {IW{1'b0}};
            state_r <= DONE;
`ifdef SUB_RANGE_CHECK_EN
            range_err_r <= bout_s | r_s[WBIT];
`endif
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign diff      = res_r;

`ifdef SUB_RANGE_CHECK_EN
  assign range_err = range_err_r;
`else
  assign range_err = 1'b0;
`endif

endmodule
